// File: rtl/spi_ctrl_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_ctrl_master_if
// Purpose  : Request handshake, frame settings and SPI pins of spi_ctrl_master.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_ctrl_master_if;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] filter_index;
    logic       color_invert;
    logic       grayscale;
    logic       SCLK;
    logic       MOSI;
    logic       SS;
    logic       o_busy;
    logic       o_done;

    modport master (
        input  i_valid, filter_index, color_invert, grayscale,
        output o_ready, SCLK, MOSI, SS, o_busy, o_done
    );

    modport slave (
        output i_valid, filter_index, color_invert, grayscale,
        input  o_ready, SCLK, MOSI, SS, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/spi_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_ctrl_master
// Purpose  : SPI mode-0 master sending one 8-bit filter control frame, MSB first.
//            Optional: SPI_CTRL_AUTO_SEND_EN starts a frame whenever the settings
//            differ from the last frame sent.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ctrl_master #(
    parameter int CLK_DIV  = 4,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2,
    parameter int GAP      = 4
) (
    input  logic               clock,
    input  logic               reset,
    spi_ctrl_master_if.master  bus
);

    localparam int c_M1     = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
    localparam int c_M2     = (SS_HOLD > GAP) ? SS_HOLD : GAP;
    localparam int c_MAXLEN = (c_M1 > c_M2) ? c_M1 : c_M2;
    localparam int c_CW     = (c_MAXLEN > 1) ? $clog2(c_MAXLEN) : 1;

    localparam logic [c_CW-1:0] c_SETUP_LAST = c_CW'(SS_SETUP - 1);
    localparam logic [c_CW-1:0] c_DIV_LAST   = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_HOLD_LAST  = c_CW'(SS_HOLD - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_HOLD     = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_ss;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        w_shift_nxt;
    logic              w_ss_nxt;
    logic              w_sclk_nxt;
    logic              w_mosi_nxt;
    logic              w_done_nxt;
    logic              w_cnt_end;
    logic              w_start;
    logic              w_accept;
    logic [5:0]        w_settings;
    logic [7:0]        w_frame;

    assign w_settings = {bus.grayscale, bus.color_invert, bus.filter_index};
    // Bit 7 clear selects the receiver's unshifted decode.
    assign w_frame    = {2'b00, w_settings};

`ifdef SPI_CTRL_AUTO_SEND_EN
    logic [5:0] r_shadow;

    assign w_start = bus.i_valid || (w_settings != r_shadow);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shadow <= 6'd0;
        end else if (w_accept) begin
            r_shadow <= w_settings;
        end
    end
`else
    assign w_start = bus.i_valid;
`endif

    assign w_accept = r_ready && (r_state == S_IDLE) && w_start;

    always_comb begin
        w_cnt_end = 1'b0;
        case (r_state)
            S_SETUP:    w_cnt_end = (r_cnt == c_SETUP_LAST);
            S_SHIFT_LO: w_cnt_end = (r_cnt == c_DIV_LAST);
            S_SHIFT_HI: w_cnt_end = (r_cnt == c_DIV_LAST);
            S_HOLD:     w_cnt_end = (r_cnt == c_HOLD_LAST);
            S_GAP:      w_cnt_end = (r_cnt == c_GAP_LAST);
            default:    w_cnt_end = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_ss_nxt    = r_ss;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_done_nxt  = 1'b0;

        if (r_state != S_IDLE) begin
            w_cnt_nxt = w_cnt_end ? '0 : r_cnt + c_CW'(1);
        end

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_ss_nxt   = 1'b1;
                w_sclk_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_shift_nxt = w_frame;
                    w_bit_nxt   = 3'd0;
                    w_ss_nxt    = 1'b0;
                    w_mosi_nxt  = w_frame[7];
                end
            end
            S_SETUP: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_SHIFT_HI;
                    w_sclk_nxt  = 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (w_cnt_end) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bit != 3'd7) begin
                        // MOSI moves to the next bit together with the SCLK fall.
                        w_state_nxt = S_SHIFT_LO;
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_mosi_nxt  = r_shift[6];
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_GAP;
                    w_ss_nxt    = 1'b1;
                    w_mosi_nxt  = 1'b0;
                end
            end
            S_GAP: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_ss_nxt    = 1'b1;
                w_sclk_nxt  = 1'b0;
                w_mosi_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_ss    <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_ss    <= w_ss_nxt;
            r_sclk  <= w_sclk_nxt;
            r_mosi  <= w_mosi_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.SS      = r_ss;
    assign bus.SCLK    = r_sclk;
    assign bus.MOSI    = r_mosi;

endmodule
`default_nettype wire
